// File: rtl/ahb_uart_rx_slave.sv
// AHB-Lite zero-wait-state slave receiving 8N1 UART frames into a small FIFO.
// Ports:
//   clk, rstn                 clock (rising edge) and asynchronous active-low reset
//   hsel, haddr, htrans,      AHB-Lite address phase (only haddr[3:2] decoded)
//   hwrite, hready
//   hwdata                    write data (data phase)
//   hrdata                    read data, combinational in the read data phase
//   hreadyout, hresp          tied to 1 / 0 (always ready, always OKAY)
//   rx_pin                    UART serial input, idle high
//   rx_irq                    registered, high while the FIFO holds data
// Register map: 0x0 RXDATA (read pops), 0x4 STATUS (write 1 to clear bits 5/6).
module ahb_uart_rx_slave #(
    parameter int unsigned CLK_FRE        = 50,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      hsel,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic                      hready,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata,
    output logic [AHB_DATA_WIDTH-1:0] hrdata,
    output logic                      hreadyout,
    output logic                      hresp,
    input  logic                      rx_pin,
    output logic                      rx_irq
);

    localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int unsigned HALF  = CYCLE / 2;
    localparam int unsigned CNT_W = $clog2(CYCLE + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         bit_idx, bit_idx_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               push_c, frame_set_c;
    logic               rx_meta, rx_s, rx_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   count, count_nxt;
    logic               empty_c, full_c, pop_c, push_ok_c, ovr_set_c;
    logic               overrun, frame_err;

    logic               dp_valid, dp_write;
    logic [1:0]         dp_addr;
    logic               rd_c, wr_status_c;
    logic [AHB_DATA_WIDTH-1:0] status_c;
    logic               unused_c;

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign unused_c  = ^{haddr, hwdata, htrans[0]};

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // RX FSM state and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    // RX FSM next state: sample mid-bit, LSB first
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rx_d && !rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_W'(CYCLE - 1)) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_W'(CYCLE - 1)) begin
                    cnt_nxt     = '0;
                    push_c      = rx_s;
                    frame_set_c = !rx_s;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // AHB address-phase capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else begin
            dp_valid <= hsel & hready & htrans[1];
            if (hsel & hready & htrans[1]) begin
                dp_write <= hwrite;
                dp_addr  <= haddr[3:2];
            end
        end
    end

    assign rd_c        = dp_valid && !dp_write;
    assign wr_status_c = dp_valid && dp_write && (dp_addr == 2'd1);
    assign empty_c     = (count == '0);
    assign full_c      = (count == LVL_W'(FIFO_DEPTH));
    assign pop_c       = rd_c && (dp_addr == 2'd0) && !empty_c;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push_ok_c   = push_c && (!full_c || pop_c);
    assign ovr_set_c   = push_c && full_c && !pop_c;

    always_comb begin
        count_nxt = count;
        case ({push_ok_c, pop_c})
            2'b10:   count_nxt = count + LVL_W'(1);
            2'b01:   count_nxt = count - LVL_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= shift;
    end

    // FIFO pointers, sticky flags and interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_nxt;
            rx_irq <= (count_nxt != '0);
            if (ovr_set_c)                       overrun <= 1'b1;
            else if (wr_status_c && hwdata[5])   overrun <= 1'b0;
            if (frame_set_c)                     frame_err <= 1'b1;
            else if (wr_status_c && hwdata[6])   frame_err <= 1'b0;
        end
    end

    always_comb begin
        status_c      = '0;
        status_c[0]   = !empty_c;
        status_c[1]   = full_c;
        status_c[4:2] = 3'(count);
        status_c[5]   = overrun;
        status_c[6]   = frame_err;
    end

    // Read mux, zero outside a read data phase
    always_comb begin
        hrdata = '0;
        if (rd_c) begin
            case (dp_addr)
                2'd0:    if (!empty_c) hrdata = AHB_DATA_WIDTH'(mem[rd_ptr]);
                2'd1:    hrdata = status_c;
                default: hrdata = '0;
            endcase
        end
    end

endmodule
